alu: RTL and testbench



---
 rtl/alu.sv | 112 +++++++++++
 tb/tb_alu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- 32-bit execute-stage ALU for the MIPS-subset datapath.
//
// Computes one of ten operations on A and B, selected by Op. It flags a zero
// result for branch resolution and a signed overflow on ADD/SUB. A registered
// copy of the result and zero flag serves stages that sample on the clock.
//
// Ports
//   Clk      in   1   rising-edge clock, used by OutReg/ZeroReg only
//   Reset    in   1   asynchronous active-high, clears OutReg/ZeroReg
//   A        in  32   operand A; only operand for NOT and shift/rotate ops
//   B        in  32   operand B
//   Op       in   4   operation select
//   Out      out 32   combinational result
//   Zero     out  1   combinational, Out == 0
//   Ovf      out  1   combinational signed overflow (ADD/SUB only)
//   OutReg   out 32   Out captured on rising Clk
//   ZeroReg  out  1   Zero captured on rising Clk
// -----------------------------------------------------------------------------
module alu (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  Op,
  output logic [31:0] Out,
  output logic        Zero,
  output logic        Ovf,
  output logic [31:0] OutReg,
  output logic        ZeroReg
);

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_ROL = 4'b1100;
  localparam logic [3:0] OP_ROR = 4'b1101;

  // Addition overflows when both operands share a sign and the result does not.
  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Subtraction overflows when the operand signs differ and the result sign
  // departs from the minuend.
  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] d);
    return (a[DATA_W-1] != b[DATA_W-1]) && (d[DATA_W-1] != a[DATA_W-1]);
  endfunction

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] sum_s;
  logic signed [DATA_W-1:0] diff_s;

  assign a_s    = signed'(A);
  assign b_s    = signed'(B);
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;

  // ---- combinational result and flags ----
  always_comb begin
    Out = '0;
    Ovf = 1'b0;
    case (Op)
      OP_ADD: begin
        Out = sum_s;
        Ovf = add_ovf(a_s, b_s, sum_s);
      end
      OP_SUB: begin
        Out = diff_s;
        Ovf = sub_ovf(a_s, b_s, diff_s);
      end
      OP_AND: Out = A & B;
      OP_OR:  Out = A | B;
      OP_NOT: Out = ~A;
      OP_SRA: Out = a_s >>> 1;
      OP_SRL: Out = A >> 1;
      OP_SLL: Out = A << 1;
      OP_ROL: Out = {A[DATA_W-2:0], A[DATA_W-1]};
      OP_ROR: Out = {A[0], A[DATA_W-1:1]};
      default: begin
        Out = '0;
        Ovf = 1'b0;
      end
    endcase
  end

  assign Zero = ~|Out;

  // ---- registered copy for clocked consumers ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OutReg  <= '0;
      ZeroReg <= 1'b1;
    end else begin
      OutReg  <= Out;
      ZeroReg <= Zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu using expectation queues for the
// combinational and registered outputs.
// -----------------------------------------------------------------------------
module tb_alu;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  Op = '0;
  logic [31:0] Out;
  logic        Zero;
  logic        Ovf;
  logic [31:0] OutReg;
  logic        ZeroReg;

  alu dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .A      (A),
    .B      (B),
    .Op     (Op),
    .Out    (Out),
    .Zero   (Zero),
    .Ovf    (Ovf),
    .OutReg (OutReg),
    .ZeroReg(ZeroReg)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic        zero;
    logic        ovf;
  } comb_exp_t;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic        zero;
  } reg_exp_t;

  comb_exp_t cq[$];
  reg_exp_t  rq[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Independent reference: overflow from a 33-bit sign-extended sum.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output logic v);
    logic [32:0] w;
    r = 32'h0;
    v = 1'b0;
    case (op)
      4'b0000: begin w = {a[31], a} + {b[31], b}; r = w[31:0]; v = w[32] ^ w[31]; end
      4'b0001: begin w = {a[31], a} - {b[31], b}; r = w[31:0]; v = w[32] ^ w[31]; end
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = ~a;
      4'b1000: r = {a[31], a[31:1]};
      4'b1010: r = {1'b0, a[31:1]};
      4'b1001: r = {a[30:0], 1'b0};
      4'b1100: r = {a[30:0], a[31]};
      4'b1101: r = {a[0], a[31:1]};
      default: r = 32'h0;
    endcase
    z = (r == 32'h0);
  endtask

  task automatic pop_comb();
    comb_exp_t e;
    if (cq.size() == 0) begin
      check("comb_queue_empty", 32'd0, 32'd1);
    end else begin
      e = cq.pop_front();
      check({e.tag, ".out"},  Out,           e.out);
      check({e.tag, ".zero"}, {31'b0, Zero}, {31'b0, e.zero});
      check({e.tag, ".ovf"},  {31'b0, Ovf},  {31'b0, e.ovf});
    end
  endtask

  task automatic pop_reg();
    reg_exp_t e;
    if (rq.size() == 0) begin
      check("reg_queue_empty", 32'd0, 32'd1);
    end else begin
      e = rq.pop_front();
      check({e.tag, ".outreg"},  OutReg,           e.out);
      check({e.tag, ".zeroreg"}, {31'b0, ZeroReg}, {31'b0, e.zero});
    end
  endtask

  task automatic drive_exp(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eo, input logic ez,
                           input logic ev);
    Op = op;
    A  = a;
    B  = b;
    cq.push_back('{tag, eo, ez, ev});
    #1;
    pop_comb();
  endtask

  logic [3:0]  unused_ops [6] = '{4'b0101, 4'b0110, 4'b0111, 4'b1011, 4'b1110, 4'b1111};
  logic [31:0] corner     [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                                  32'hFFFF_FFFF, 32'h8000_0001};

  initial begin
    logic [31:0] ra, rb, eo;
    logic [3:0]  rop;
    logic        ez, ev;

    // Reset state
    #1 Reset = 1'b1;
    #1;
    rq.push_back('{"reset", 32'h0, 1'b1});
    pop_reg();
    @(negedge Clk);
    Reset = 1'b0;

    // Basic ops with A=0, B=1
    drive_exp("add01", 4'b0000, 32'h0, 32'h1, 32'h1, 1'b0, 1'b0);
    drive_exp("and01", 4'b0010, 32'h0, 32'h1, 32'h0, 1'b1, 1'b0);
    drive_exp("or01",  4'b0011, 32'h0, 32'h1, 32'h1, 1'b0, 1'b0);
    drive_exp("not01", 4'b0100, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    drive_exp("sra01", 4'b1000, 32'h0, 32'h1, 32'h0, 1'b1, 1'b0);
    drive_exp("srl01", 4'b1010, 32'h0, 32'h1, 32'h0, 1'b1, 1'b0);
    drive_exp("sll01", 4'b1001, 32'h0, 32'h1, 32'h0, 1'b1, 1'b0);
    drive_exp("rol01", 4'b1100, 32'h0, 32'h1, 32'h0, 1'b1, 1'b0);
    drive_exp("ror01", 4'b1101, 32'h0, 32'h1, 32'h0, 1'b1, 1'b0);

    // Subtraction and overflow
    drive_exp("sub11",   4'b0001, 32'h1, 32'h1, 32'h0, 1'b1, 1'b0);
    drive_exp("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    drive_exp("sub_ovf", 4'b0001, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    drive_exp("add_neg", 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    drive_exp("sub_nov", 4'b0001, 32'h0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);

    // Shifts and rotates with A=80000001
    drive_exp("sra81", 4'b1000, 32'h8000_0001, 32'h0, 32'hC000_0000, 1'b0, 1'b0);
    drive_exp("srl81", 4'b1010, 32'h8000_0001, 32'h0, 32'h4000_0000, 1'b0, 1'b0);
    drive_exp("sll81", 4'b1001, 32'h8000_0001, 32'h0, 32'h0000_0002, 1'b0, 1'b0);
    drive_exp("rol81", 4'b1100, 32'h8000_0001, 32'h0, 32'h0000_0003, 1'b0, 1'b0);
    drive_exp("ror81", 4'b1101, 32'h8000_0001, 32'h0, 32'hC000_0000, 1'b0, 1'b0);

    // Unused opcodes
    foreach (unused_ops[i])
      drive_exp($sformatf("unused%0d", i), unused_ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h0, 1'b1, 1'b0);

    // Registered path and asynchronous reset
    @(negedge Clk);
    drive_exp("reg_add", 4'b0000, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0);
    rq.push_back('{"reg_capture", 32'h5, 1'b0});
    @(posedge Clk);
    #1 pop_reg();
    #2 Reset = 1'b1;
    #1;
    rq.push_back('{"reg_async_rst", 32'h0, 1'b1});
    pop_reg();
    cq.push_back('{"rst_comb", 32'h5, 1'b0, 1'b0});
    pop_comb();
    rq.push_back('{"reg_rst_held", 32'h0, 1'b1});
    @(posedge Clk);
    #1 pop_reg();
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    rq.push_back('{"reg_rel_noedge", 32'h0, 1'b1});
    pop_reg();
    rq.push_back('{"reg_release", 32'h5, 1'b0});
    @(posedge Clk);
    #1 pop_reg();

    // Mixed vectors through both paths
    for (int i = 0; i < 48; i++) begin
      @(negedge Clk);
      ra  = (i % 3 == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb  = (i % 4 == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rop = 4'($urandom_range(0, 15));
      model(rop, ra, rb, eo, ez, ev);
      drive_exp($sformatf("rnd%0d_op%0h", i, rop), rop, ra, rb, eo, ez, ev);
      rq.push_back('{$sformatf("rnd%0d", i), eo, ez});
      @(posedge Clk);
      #1 pop_reg();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
